// File: rtl/link_tx_gen_if.sv
// Handshake and status bundle between the link frequency controller and the square-wave generator.
interface link_tx_gen_if;
    logic        enable;
    logic [31:0] f_req;
    logic        f_req_valid;
    logic        f_req_ready;
    logic        link;
    logic [31:0] f_act;
    logic        freq_rdy;
    logic        busy;
    logic        err;

    modport master (
        output enable, f_req, f_req_valid,
        input  f_req_ready, link, f_act, freq_rdy, busy, err
    );

    modport slave (
        input  enable, f_req, f_req_valid,
        output f_req_ready, link, f_act, freq_rdy, busy, err
    );
endinterface

// File: rtl/link_tx_gen.sv
// SWIPT link transmit generator: converts a requested frequency to a half-period with a
// bit-serial divider and swaps it in only at a link edge so no level is ever cut short.
module link_tx_gen #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned F_MIN  = 20000,
    parameter int unsigned F_MAX  = 200000,
    parameter int unsigned F_INIT = 40000
) (
    input logic          clk,
    input logic          rst,
    link_tx_gen_if.slave bus
);
    localparam logic [31:0] HP_INIT = 32'(CLK_HZ / (2 * F_INIT));

    typedef enum logic [1:0] {L_IDLE, L_DIV, L_PEND} lstate_t;

    lstate_t     state, state_nxt;
    logic [31:0] f_lat;
    logic [31:0] dq;       // dividend bits shift out as quotient bits shift in
    logic [32:0] rem;
    logic [4:0]  div_cnt;
    logic [31:0] hp_cur, cnt, f_act_q;
    logic        link_q, freq_rdy_q, err_q;

    logic        in_range, accept, start, toggle, apply, rem_ge;
    logic [33:0] rem_sh, divisor;

    assign in_range = (bus.f_req >= F_MIN) && (bus.f_req <= F_MAX);
    assign accept   = bus.f_req_valid && (state == L_IDLE);
    assign start    = accept && in_range;
    assign toggle   = bus.enable && (cnt == 32'd1);
    // A pending result lands at the next toggle, or at once while the generator is idle.
    assign apply    = (state == L_PEND) && (toggle || !bus.enable);

    assign divisor  = {1'b0, f_lat, 1'b0};
    assign rem_sh   = {rem, dq[31]};
    assign rem_ge   = (rem_sh >= divisor);

    assign bus.f_req_ready = (state == L_IDLE);
    assign bus.busy        = (state != L_IDLE);
    assign bus.link        = link_q;
    assign bus.f_act       = f_act_q;
    assign bus.freq_rdy    = freq_rdy_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= L_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            L_IDLE:  if (start) state_nxt = L_DIV;
            L_DIV:   if (div_cnt == 5'd31) state_nxt = L_PEND;
            L_PEND:  if (apply) state_nxt = L_IDLE;
            default: state_nxt = L_IDLE;
        endcase
    end

    // Restoring divide: one quotient bit per cycle, 32 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_lat   <= '0;
            dq      <= '0;
            rem     <= '0;
            div_cnt <= '0;
        end else if (start) begin
            f_lat   <= bus.f_req;
            dq      <= 32'(CLK_HZ);
            rem     <= '0;
            div_cnt <= '0;
        end else if (state == L_DIV) begin
            rem     <= rem_ge ? 33'(rem_sh - divisor) : rem_sh[32:0];
            dq      <= {dq[30:0], rem_ge};
            div_cnt <= div_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_q     <= 1'b0;
            cnt        <= HP_INIT;
            hp_cur     <= HP_INIT;
            f_act_q    <= 32'(F_INIT);
            freq_rdy_q <= 1'b0;
        end else begin
            if (apply) begin
                hp_cur  <= dq;
                f_act_q <= f_lat;
            end
            if (!bus.enable) begin
                link_q     <= 1'b0;
                freq_rdy_q <= 1'b0;
                cnt        <= apply ? dq : hp_cur;
            end else if (toggle) begin
                link_q     <= ~link_q;
                freq_rdy_q <= !start;
                cnt        <= apply ? dq : hp_cur;
            end else begin
                cnt <= cnt - 32'd1;
                if (start) freq_rdy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept && !in_range;
    end
endmodule

// File: tb/tb_link_tx_gen.sv
// Directed bench for link_tx_gen: table of frequency requests plus hand-built edge-timing sequences.
module tb_link_tx_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    link_tx_gen_if bus();
    link_tx_gen dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] f;
        bit          bad;
        int          hp;
    } vec_t;

    localparam int NV = 11;
    vec_t vt[NV];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ticks until link changes level; n = -1 if it never does within lim.
    task automatic wait_toggle(input int lim, output int n);
        logic l0;
        l0 = bus.link;
        n  = -1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (bus.link !== l0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (bus.busy === 1'b0) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(nm, ok, 1);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_link"},     bus.link,        0);
        chk({nm, "_f_act"},    bus.f_act,       40000);
        chk({nm, "_freq_rdy"}, bus.freq_rdy,    0);
        chk({nm, "_ready"},    bus.f_req_ready, 1);
        chk({nm, "_busy"},     bus.busy,        0);
        chk({nm, "_err"},      bus.err,         0);
    endtask

    // Accept a request 'lead' ticks before the next edge; check remaining level and the two after.
    task automatic req_near_edge(input string nm, input int lead, input logic [31:0] f,
                                 input int hp_old, input int exp2, input int exp3);
        int n;
        wait_toggle(6000, n);
        ticks(hp_old - lead);
        bus.f_req = f;
        bus.f_req_valid = 1'b1;
        tick();
        bus.f_req_valid = 1'b0;
        wait_toggle(6000, n);
        chk({nm, "_rest"}, n, lead - 1);
        wait_toggle(6000, n);
        chk({nm, "_lvl1"}, n, exp2);
        wait_toggle(6000, n);
        chk({nm, "_lvl2"}, n, exp3);
        chk({nm, "_f_act"}, bus.f_act, f);
    endtask

    initial begin
        int n;
        logic [31:0] prev;

        vt[0]  = '{32'd19999,      1'b1, 0};
        vt[1]  = '{32'd200001,     1'b1, 0};
        vt[2]  = '{32'd0,          1'b1, 0};
        vt[3]  = '{32'hFFFF_FFFF,  1'b1, 0};
        vt[4]  = '{32'd20000,      1'b0, 2500};
        vt[5]  = '{32'd200000,     1'b0, 250};
        vt[6]  = '{32'd33333,      1'b0, 1500};
        vt[7]  = '{32'd123457,     1'b0, 404};
        vt[8]  = '{32'd150000,     1'b0, 333};
        vt[9]  = '{32'd19999,      1'b1, 0};
        vt[10] = '{32'd40000,      1'b0, 1250};

        bus.enable      = 1'b0;
        bus.f_req       = '0;
        bus.f_req_valid = 1'b0;

        // Reset values, then default 40 kHz waveform.
        ticks(3);
        chk_reset("rst");
        rst = 1'b0;
        bus.enable = 1'b1;
        wait_toggle(3000, n);
        chk("first_rise", n, 1250);
        chk("first_rise_link", bus.link, 1);
        chk("first_rise_rdy", bus.freq_rdy, 1);
        chk("init_f_act", bus.f_act, 32'h9C40);
        wait_toggle(3000, n);
        chk("init_high", n, 1250);
        wait_toggle(3000, n);
        chk("init_low", n, 1250);

        // Mid-level request: level in progress finishes at 1250, then 1000.
        wait_toggle(3000, n);
        ticks(100);
        bus.f_req = 32'd50000;
        bus.f_req_valid = 1'b1;
        tick();
        bus.f_req_valid = 1'b0;
        chk("mid_busy", bus.busy, 1);
        chk("mid_ready", bus.f_req_ready, 0);
        chk("mid_rdy_clr", bus.freq_rdy, 0);
        ticks(31);
        chk("mid_f_act_hold", bus.f_act, 40000);
        chk("mid_busy_late", bus.busy, 1);
        wait_toggle(3000, n);
        chk("mid_level_done", n + 132, 1250);
        chk("mid_f_act", bus.f_act, 50000);
        chk("mid_idle", bus.busy, 0);
        wait_toggle(3000, n);
        chk("mid_new_level", n, 1000);

        // Result ready one cycle before an edge is applied there; on the edge cycle it waits.
        req_near_edge("edge_m1", 34, 32'd40000, 1000, 1250, 1250);
        req_near_edge("edge_eq", 33, 32'd50000, 1250, 1250, 1000);

        for (int i = 0; i < NV; i++) begin
            prev = bus.f_act;
            chk($sformatf("v%0d_ready_pre", i), bus.f_req_ready, 1);
            bus.f_req = vt[i].f;
            bus.f_req_valid = 1'b1;
            tick();
            bus.f_req_valid = 1'b0;
            if (vt[i].bad) begin
                chk($sformatf("v%0d_err", i), bus.err, 1);
                chk($sformatf("v%0d_busy", i), bus.busy, 0);
                chk($sformatf("v%0d_ready", i), bus.f_req_ready, 1);
                tick();
                chk($sformatf("v%0d_err_end", i), bus.err, 0);
                chk($sformatf("v%0d_f_act", i), bus.f_act, prev);
            end else begin
                chk($sformatf("v%0d_err", i), bus.err, 0);
                chk($sformatf("v%0d_busy", i), bus.busy, 1);
                wait_idle($sformatf("v%0d_apply", i), 6000);
                chk($sformatf("v%0d_f_act", i), bus.f_act, vt[i].f);
                chk($sformatf("v%0d_rdy", i), bus.freq_rdy, 1);
                wait_toggle(6000, n);
                chk($sformatf("v%0d_level", i), n, vt[i].hp);
            end
        end

        // Second request held during busy: blocked, then taken exactly once.
        bus.f_req = 32'd50000;
        bus.f_req_valid = 1'b1;
        tick();
        bus.f_req = 32'd100000;
        chk("hold_ready", bus.f_req_ready, 0);
        n = 0;
        for (int i = 0; i < 6000; i++) begin
            if (bus.f_req_ready === 1'b1) begin
                n = 1;
                break;
            end
            tick();
        end
        chk("hold_ready_ret", n, 1);
        chk("hold_first_f_act", bus.f_act, 50000);
        tick();
        bus.f_req_valid = 1'b0;
        chk("hold_second_busy", bus.busy, 1);
        wait_idle("hold_second_apply", 6000);
        chk("hold_second_f_act", bus.f_act, 100000);
        wait_toggle(3000, n);
        chk("hold_second_level", n, 500);
        ticks(40);
        chk("hold_no_reaccept", bus.busy, 0);

        // Disable while a result is pending: applied immediately, restart after new hp.
        wait_toggle(3000, n);
        bus.f_req = 32'd50000;
        bus.f_req_valid = 1'b1;
        tick();
        bus.f_req_valid = 1'b0;
        ticks(40);
        chk("dis_pend_busy", bus.busy, 1);
        chk("dis_pend_f_act", bus.f_act, 100000);
        bus.enable = 1'b0;
        tick();
        chk("dis_link", bus.link, 0);
        chk("dis_rdy", bus.freq_rdy, 0);
        chk("dis_f_act", bus.f_act, 50000);
        chk("dis_busy", bus.busy, 0);
        ticks(5);
        chk("dis_link_hold", bus.link, 0);
        bus.enable = 1'b1;
        wait_toggle(3000, n);
        chk("reen_first_rise", n, 1000);
        chk("reen_link", bus.link, 1);
        wait_toggle(3000, n);
        chk("reen_level", n, 1000);

        // Reset in the middle of a divide.
        bus.f_req = 32'd20000;
        bus.f_req_valid = 1'b1;
        tick();
        bus.f_req_valid = 1'b0;
        ticks(9);
        chk("div_busy_pre_rst", bus.busy, 1);
        rst = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        wait_toggle(3000, n);
        chk("post_rst_rise", n, 1250);
        wait_toggle(3000, n);
        chk("post_rst_level", n, 1250);
        chk("post_rst_f_act", bus.f_act, 40000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
